mux_sel_scan: RTL and testbench
===============================

Name: mux_sel_scan

Overview:
Parametrised successor to the lab's combinational 5-to-1 selector. Selects one of NUM_CH DATA_WIDTH-bit channels and registers it with a valid/ready output handshake. Two modes:
- Manual: channel chosen by a binary select.
- Auto-scan: round-robin through all channels with a programmable dwell.

Sits between the switch/data inputs and display or downstream logic on the board.

Parameters:
DATA_WIDTH, 3, width of each channel
NUM_CH, 5, number of input channels (2..16)
SEL_WIDTH, 3, select width; must satisfy 2**SEL_WIDTH >= NUM_CH
DWELL, 4, accepted samples per channel in scan mode (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sampling enable
mode  input  1  0 = manual, 1 = auto-scan
sel  input  SEL_WIDTH  manual channel select
data_in  input  NUM_CH*DATA_WIDTH  flattened channels; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
out_ready  input  1  downstream accepts out_data
out_valid  output  1  out_data/out_ch valid
out_data  output  DATA_WIDTH  registered selected data
out_ch  output  SEL_WIDTH  channel index of out_data

Behaviour:
- Single clock domain. Reset is asynchronous, active-low. All state updates on the rising edge of clk.
- Reset values: out_valid=0, out_data=0, out_ch=0, scan channel=0, dwell count=0, state=MANUAL.
- State machine:
  - Two states, MANUAL and SCAN; the state follows the mode input, registered.
  - MANUAL->SCAN transition (mode 0->1 seen at an edge): scan channel=0, dwell count=0.
  - SCAN->MANUAL transition: dwell count=0.
- Effective channel:
  - MANUAL: sel clamped; sel >= NUM_CH selects channel NUM_CH-1 (matches legacy behaviour where s2=1 picks the last input regardless of s1/s0).
  - SCAN: the scan channel register.
- Load condition: load = en && (!out_valid || out_ready).
- On load:
  - out_data <= data_in[effective channel], out_ch <= effective channel, out_valid <= 1.
  - Latency: 1 cycle from input to output.
- When en=0 and (!out_valid || out_ready): out_valid <= 0. out_data and out_ch hold their last values.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid hold. Input changes are ignored; the dwell count does not advance.
- Scan advance:
  - Each load in SCAN increments the dwell count.
  - When the count reaches DWELL-1 on a load, the count is cleared and the scan channel advances.
  - Scan channel wraps NUM_CH-1 -> 0.
  - With DWELL=1 the channel advances on every load.
- Mode switch in the same cycle as a load: the load uses the new mode's effective channel. In SCAN that is channel 0, and it counts as the first dwell sample.
- Reset mid-operation: all registers return to reset values immediately. out_valid=0 in the same cycle rst_n falls.
- Width rules: out_ch is zero-extended channel index; no arithmetic on data.

Optional Feature:
MUX_PARITY_EN:
- Defined: adds output port out_parity (1 bit). It is registered with out_data on every load and holds with it on stall. out_parity = XOR of all bits of the loaded data (even parity). Reset value 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
Parameters for all scenarios: DATA_WIDTH=3, NUM_CH=5, DWELL=2. Channels 0..4 = 1,2,5,6,7.
1. Reset: hold rst_n=0 with en=1 -> out_valid=0, out_data=0, out_ch=0. Release -> first edge with en=1, sel=0 gives out_data=1, out_valid=1.
2. Manual select: mode=0, sel=2, out_ready=1 -> next edge out_data=5, out_ch=2. sel=6 -> out_ch=4, out_data=7.
3. Backpressure: out_valid=1, out_ready=0, sel changes 2->3 for 3 cycles -> out_data stays 5. out_ready=1 -> next edge out_data=6.
4. Scan: mode=1, en=1, out_ready=1 -> out_ch sequence 0,0,1,1,2,2,3,3,4,4,0,0. Check wrap.
5. Scan stall: drop out_ready for 4 cycles during the first sample of channel 2 -> after release, channel 2 is output once more before advancing to 3.
6. Reset mid-scan at channel 3 -> out_valid=0 asynchronously. After release, with mode=1 held, the sequence restarts 0,0,1; en=0 -> out_valid=0 after any pending accept.

Source files
------------

// File: rtl/mux_sel_scan.sv
// Registered NUM_CH-to-1 channel selector with valid/ready output, manual or round-robin scan mode.
// Optional build macro MUX_PARITY_EN adds an even-parity output registered alongside out_data.
module mux_sel_scan #(
    parameter int DATA_WIDTH = 3,
    parameter int NUM_CH     = 5,
    parameter int SEL_WIDTH  = 3,
    parameter int DWELL      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         mode,
    input  logic [SEL_WIDTH-1:0]         sel,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [SEL_WIDTH-1:0]         out_ch
`ifdef MUX_PARITY_EN
    ,
    output logic                         out_parity
`endif
);

    // Handshake: out_data/out_ch transfer on any edge where out_valid && out_ready;
    // while out_valid && !out_ready everything on the output side holds.
    localparam logic ST_MANUAL = 1'b0;
    localparam logic ST_SCAN   = 1'b1;

    localparam int                   CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_WIDTH-1:0] CH_LAST  = SEL_WIDTH'(NUM_CH - 1);

    logic                  state;
    logic [SEL_WIDTH-1:0]  scan_ch;
    logic [CNT_W-1:0]      dwell_cnt;

    logic                  out_free;
    logic                  load;
    logic                  entering_scan;
    logic [SEL_WIDTH-1:0]  eff_ch;
    logic [SEL_WIDTH-1:0]  next_ch;
    logic [CNT_W-1:0]      dwell_base;
    logic [DATA_WIDTH-1:0] sel_data;

    assign out_free      = !out_valid || out_ready;
    assign load          = en && out_free;
    assign entering_scan = mode && (state == ST_MANUAL);

    // The mode input (not the registered state) decides the channel, so a load
    // on the switching edge already uses the new mode; scan entry starts at channel 0.
    always_comb begin
        eff_ch = '0;
        if (!mode) begin
            eff_ch = (sel > CH_LAST) ? CH_LAST : sel;
        end else if (!entering_scan) begin
            eff_ch = scan_ch;
        end
    end

    assign dwell_base = entering_scan ? '0 : dwell_cnt;
    assign next_ch    = (eff_ch == CH_LAST) ? '0 : eff_ch + SEL_WIDTH'(1);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (eff_ch == SEL_WIDTH'(k)) begin
                sel_data = data_in[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_MANUAL;
            scan_ch   <= '0;
            dwell_cnt <= '0;
        end else begin
            state <= mode ? ST_SCAN : ST_MANUAL;
            if (mode && load) begin
                if (dwell_base == CNT_LAST) begin
                    dwell_cnt <= '0;
                    scan_ch   <= next_ch;
                end else begin
                    dwell_cnt <= dwell_base + CNT_W'(1);
                    scan_ch   <= eff_ch;
                end
            end else if (entering_scan) begin
                scan_ch   <= '0;
                dwell_cnt <= '0;
            end else if (!mode && state == ST_SCAN) begin
                dwell_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_ch    <= eff_ch;
        end else if (out_free) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_parity <= 1'b0;
        end else if (load) begin
            out_parity <= ^sel_data;
        end
    end
`endif

endmodule

// File: tb/tb_mux_sel_scan.sv
// Directed bench for mux_sel_scan: reset, manual select, backpressure, scan, scan stall, reset mid-scan.
module tb_mux_sel_scan;
    localparam int DATA_WIDTH = 3;
    localparam int NUM_CH     = 5;
    localparam int SEL_WIDTH  = 3;
    localparam int DWELL      = 2;

    logic                         clk;
    logic                         rst_n;
    logic                         en;
    logic                         mode;
    logic [SEL_WIDTH-1:0]         sel;
    logic [NUM_CH*DATA_WIDTH-1:0] data_in;
    logic                         out_ready;
    logic                         out_valid;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [SEL_WIDTH-1:0]         out_ch;
`ifdef MUX_PARITY_EN
    logic                         out_parity;
`endif

    int n_checks = 0;
    int n_passed = 0;

    logic [DATA_WIDTH-1:0] ch_val [NUM_CH] = '{3'd1, 3'd2, 3'd5, 3'd6, 3'd7};
    int scan_seq [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0};

    mux_sel_scan #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_CH    (NUM_CH),
        .SEL_WIDTH (SEL_WIDTH),
        .DWELL     (DWELL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .sel      (sel),
        .data_in  (data_in),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ch   (out_ch)
`ifdef MUX_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [DATA_WIDTH-1:0] d,
                              input logic [SEL_WIDTH-1:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".ch"},    32'(out_ch),    32'(c));
`ifdef MUX_PARITY_EN
        check({tag, ".parity"}, 32'(out_parity), 32'(^d));
`endif
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        data_in   = {3'd7, 3'd6, 3'd5, 3'd2, 3'd1};
        rst_n     = 1'b0;
        en        = 1'b1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;

        // 1. reset held with en=1
        step();
        step();
        expect_out("reset_hold", 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;
        step();
        expect_out("first_load", 1'b1, 3'd1, 3'd0);

        // 2. manual select with clamp
        sel = 3'd2;
        step();
        expect_out("manual_sel2", 1'b1, 3'd5, 3'd2);
        sel = 3'd6;
        step();
        expect_out("manual_clamp6", 1'b1, 3'd7, 3'd4);

        // 3. backpressure
        sel = 3'd2;
        step();
        expect_out("bp_pre", 1'b1, 3'd5, 3'd2);
        out_ready = 1'b0;
        sel       = 3'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("bp_hold%0d", i), 1'b1, 3'd5, 3'd2);
        end
        out_ready = 1'b1;
        step();
        expect_out("bp_release", 1'b1, 3'd6, 3'd3);

        // 4. scan with wrap
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            expect_out($sformatf("scan%0d", i), 1'b1, ch_val[scan_seq[i]], SEL_WIDTH'(scan_seq[i]));
        end

        // 5. stall during first sample of channel 2
        step();
        expect_out("stall_c1a", 1'b1, ch_val[1], 3'd1);
        step();
        expect_out("stall_c1b", 1'b1, ch_val[1], 3'd1);
        step();
        expect_out("stall_c2a", 1'b1, ch_val[2], 3'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_out($sformatf("stall_hold%0d", i), 1'b1, ch_val[2], 3'd2);
        end
        out_ready = 1'b1;
        step();
        expect_out("stall_c2b", 1'b1, ch_val[2], 3'd2);
        step();
        expect_out("stall_c3a", 1'b1, ch_val[3], 3'd3);

        // 6. asynchronous reset mid-scan
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 3'd0, 3'd0);
        step();
        expect_out("reset_held", 1'b0, 3'd0, 3'd0);
        rst_n = 1'b1;
        step();
        expect_out("restart0", 1'b1, ch_val[0], 3'd0);
        step();
        expect_out("restart1", 1'b1, ch_val[0], 3'd0);
        step();
        expect_out("restart2", 1'b1, ch_val[1], 3'd1);

        // en=0 with a pending (unaccepted) output, then accept
        en        = 1'b0;
        out_ready = 1'b0;
        step();
        expect_out("en0_pending", 1'b1, ch_val[1], 3'd1);
        out_ready = 1'b1;
        step();
        expect_out("en0_drop", 1'b0, ch_val[1], 3'd1);
        step();
        expect_out("en0_idle", 1'b0, ch_val[1], 3'd1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end
endmodule
